// File: rtl/uart_tx_word.sv
// uart_tx_word: serialises one word as NBYTES back-to-back 8N1 frames on a
// single line. The highest selected byte goes first, and each byte is sent
// LSB first. The framing matches the ROM-load receiver, so the two can be
// looped back directly.
module uart_tx_word #(
   parameter int CLKS_PER_BIT = 870,
   parameter int NBYTES       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] word_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        tx_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);
   // Left-align the selected low bytes so the byte on air is always [31:24].
   localparam int ALIGN = 8 * (4 - NBYTES);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } stateT;

   stateT             state, stateNext;
   logic [CNT_W-1:0]  clkCnt, clkCntNext;
   logic [3:0]        bitIdx, bitIdxNext;
   logic [1:0]        byteIdx, byteIdxNext;
   logic [31:0]       shiftReg, shiftNext;
   logic              txReg, txNext;
   logic              doneReg, doneNext;
   logic [7:0]        curByte;
   logic [2:0]        nextBit;

   // Register every piece of frame state. The line level and the done pulse
   // come straight from flops, so the serial line cannot glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         clkCnt   <= '0;
         bitIdx   <= '0;
         byteIdx  <= '0;
         shiftReg <= '0;
         txReg    <= 1'b1;
         doneReg  <= 1'b0;
      end else begin
         state    <= stateNext;
         clkCnt   <= clkCntNext;
         bitIdx   <= bitIdxNext;
         byteIdx  <= byteIdxNext;
         shiftReg <= shiftNext;
         txReg    <= txNext;
         doneReg  <= doneNext;
      end
   end

   // Next-state logic. The next line level is computed together with the
   // state change, so tx is updated on the same edge as the state.
   always_comb begin
      stateNext   = state;
      clkCntNext  = clkCnt;
      bitIdxNext  = bitIdx;
      byteIdxNext = byteIdx;
      shiftNext   = shiftReg;
      txNext      = txReg;
      doneNext    = 1'b0;
      curByte     = shiftReg[31:24];
      nextBit     = bitIdx[2:0] + 3'd1;

      case (state)
         IDLE: begin
            txNext = 1'b1;
            if (valid_i) begin
               stateNext   = START;
               shiftNext   = word_i << ALIGN;
               clkCntNext  = '0;
               bitIdxNext  = '0;
               byteIdxNext = '0;
               txNext      = 1'b0;
            end
         end
         START: begin
            if (clkCnt == LAST_CLK) begin
               clkCntNext = '0;
               bitIdxNext = '0;
               stateNext  = DATA;
               txNext     = curByte[0];
            end else begin
               clkCntNext = clkCnt + 1'b1;
            end
         end
         DATA: begin
            if (clkCnt == LAST_CLK) begin
               clkCntNext = '0;
               if (bitIdx == 4'd7) begin
                  stateNext = STOP;
                  txNext    = 1'b1;
               end else begin
                  bitIdxNext = bitIdx + 4'd1;
                  txNext     = curByte[nextBit];
               end
            end else begin
               clkCntNext = clkCnt + 1'b1;
            end
         end
         STOP: begin
            if (clkCnt == LAST_CLK) begin
               clkCntNext = '0;
               if (byteIdx == LAST_BYTE) begin
                  stateNext = IDLE;
                  doneNext  = 1'b1;
                  txNext    = 1'b1;
               end else begin
                  byteIdxNext = byteIdx + 2'd1;
                  shiftNext   = shiftReg << 8;
                  stateNext   = START;
                  txNext      = 1'b0;
               end
            end else begin
               clkCntNext = clkCnt + 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
            txNext    = 1'b1;
         end
      endcase
   end

   // Handshake outputs are decoded from the registered state only.
   always_comb begin
      ready_o = (state == IDLE);
      busy_o  = (state != IDLE);
      tx_o    = txReg;
      done_o  = doneReg;
   end

endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: drives uart_tx_word with directed and random words. It
// compares the line cycle by cycle against a frame model computed from
// plain bit arithmetic.
module tb_uart_tx_word;

   localparam int CPB = 4;
   localparam int NB  = 4;
   localparam int T   = 10 * NB * CPB;

   logic        clk;
   logic        rst_n;
   logic [31:0] wordIn;
   logic        validIn;
   logic        ready;
   logic        tx;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   uart_tx_word #(.CLKS_PER_BIT(CPB), .NBYTES(NB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .word_i  (wordIn),
      .valid_i (validIn),
      .ready_o (ready),
      .tx_o    (tx),
      .busy_o  (busy),
      .done_o  (done)
   );

   // Free-running clock with a 10-unit period. Rising edges fall at 5, 15, 25 and so on.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A watchdog that stops a hung run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Returns the expected line level for cycle c of a frame. Cycle 0 is the
   // cycle after the accept edge. Each bit is one slot in a 10-slot byte
   // frame, and the slot decides the level.
   function automatic logic expBit(input logic [31:0] w, input int c);
      int bitNo, byteNo, pos;
      logic [31:0] byteVal;
      bitNo   = c / CPB;
      byteNo  = bitNo / 10;
      pos     = bitNo % 10;
      byteVal = (w >> (8 * (NB - 1 - byteNo))) & 32'hff;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return byteVal[pos-1];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sends one word starting at a negedge where ready is high. It checks
   // every frame cycle, then the completion cycle. When chainNext is set,
   // valid stays high with nextW, so the caller can send it back-to-back.
   task automatic applyStimulus(input logic [31:0] w, input bit perturb,
                                input bit chainNext, input logic [31:0] nextW);
      logic [31:0] decoded;
      logic [31:0] mask;
      int bitNo, pos, byteNo;
      decoded = '0;
      mask    = (NB == 4) ? 32'hffffffff : ((32'd1 << (8 * NB)) - 32'd1);
      checkOutput("readyBeforeAccept", {31'd0, ready}, 32'd1);
      wordIn  = w;
      validIn = 1'b1;
      for (int c = 0; c < T; c++) begin
         @(negedge clk);
         if (c == 0) begin
            if (chainNext) wordIn = nextW;
            else validIn = 1'b0;
         end
         checkOutput("txBit", {31'd0, tx}, {31'd0, expBit(w, c)});
         checkOutput("readyLowInFrame", {31'd0, ready}, 32'd0);
         checkOutput("busyHighInFrame", {31'd0, busy}, 32'd1);
         checkOutput("doneLowInFrame", {31'd0, done}, 32'd0);
         bitNo  = c / CPB;
         byteNo = bitNo / 10;
         pos    = bitNo % 10;
         if ((c % CPB) == (CPB / 2) && pos >= 1 && pos <= 8)
            decoded[8 * (NB - 1 - byteNo) + pos - 1] = tx;
         if (perturb && !chainNext && c == 37) begin
            wordIn  = $urandom;
            validIn = 1'b1;
         end
         if (perturb && !chainNext && c == 38) validIn = 1'b0;
      end
      checkOutput("decodedWord", decoded, w & mask);
      @(negedge clk);
      checkOutput("doneAtEnd", {31'd0, done}, 32'd1);
      checkOutput("readyAtEnd", {31'd0, ready}, 32'd1);
      checkOutput("busyAtEnd", {31'd0, busy}, 32'd0);
      checkOutput("txIdleAtEnd", {31'd0, tx}, 32'd1);
      if (!chainNext) begin
         @(negedge clk);
         checkOutput("doneSingleCycle", {31'd0, done}, 32'd0);
         checkOutput("readyStaysHigh", {31'd0, ready}, 32'd1);
         checkOutput("txIdleAfter", {31'd0, tx}, 32'd1);
      end
   endtask

   // The directed sequence: reset, edge patterns, back-to-back words, busy
   // perturbation, random words, mid-frame reset, and reset with valid.
   initial begin
      rst_n   = 1'b0;
      validIn = 1'b0;
      wordIn  = '0;
      repeat (3) @(negedge clk);
      checkOutput("resetTx", {31'd0, tx}, 32'd1);
      checkOutput("resetReady", {31'd0, ready}, 32'd1);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetDone", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] word 0x12345678");
      applyStimulus(32'h12345678, 1'b0, 1'b0, 32'h0);
      $display("[TB] edge patterns");
      applyStimulus(32'h00000000, 1'b0, 1'b0, 32'h0);
      applyStimulus(32'hffffffff, 1'b0, 1'b0, 32'h0);
      $display("[TB] back-to-back words");
      applyStimulus(32'hdeadbeef, 1'b0, 1'b1, 32'h00000073);
      applyStimulus(32'h00000073, 1'b0, 1'b0, 32'h0);
      $display("[TB] perturbation while busy");
      applyStimulus($urandom, 1'b1, 1'b0, 32'h0);
      $display("[TB] random words");
      for (int i = 0; i < 3; i++) applyStimulus($urandom, 1'b0, 1'b0, 32'h0);

      $display("[TB] reset during byte 2");
      wordIn  = $urandom;
      validIn = 1'b1;
      @(negedge clk);
      validIn = 1'b0;
      repeat (89) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midResetTx", {31'd0, tx}, 32'd1);
      checkOutput("midResetReady", {31'd0, ready}, 32'd1);
      checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postResetTx", {31'd0, tx}, 32'd1);
      checkOutput("postResetDone", {31'd0, done}, 32'd0);
      applyStimulus($urandom, 1'b0, 1'b0, 32'h0);

      $display("[TB] reset with valid");
      rst_n   = 1'b0;
      validIn = 1'b1;
      wordIn  = 32'h0f0f0f0f;
      @(posedge clk);
      #1;
      checkOutput("rstValidReady", {31'd0, ready}, 32'd1);
      checkOutput("rstValidTx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      validIn = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      checkOutput("rstValidNoAccept", {31'd0, ready}, 32'd1);
      checkOutput("rstValidLineIdle", {31'd0, tx}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
